seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Sequential signed binary divider, the inverse companion of the sequential Booth multiplier in the arithmetic-lab datapath. It accepts an N-bit two's-complement dividend and divisor on a load strobe and performs restoring division on magnitudes, one quotient bit per clock. It then applies sign correction and presents a quotient and remainder truncated toward zero, with a done flag. It sits alongside the multiplier as a load-then-compute arithmetic unit driven by the same clk/rst/load style controller.

## Interface
- N, 8: operand width in bits; also sets the iteration count (N ≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- load  input  1  sampled on clk; when high, latches A/B and starts a division.
- A  input  N  signed dividend.
- B  input  N  signed divisor.
- quot  output  N  signed quotient, registered.
- rem  output  N  signed remainder, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  high when quot/rem hold a completed result.
- div_by_zero  output  1  divisor-zero flag; functional only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset values: state IDLE; quot=0, rem=0, busy=0, done=0, div_by_zero=0; internal registers and counter 0.
- Load has priority over every state. It latches the magnitudes |A| and |B| as N-bit unsigned values, so |−2^(N−1)| = 2^(N−1) fits.
  - Load also latches sign_q = A[N−1]^B[N−1] and sign_r = A[N−1].
  - It clears the partial remainder (N+1 bits) and the counter, clears done, and goes to RUN.
- RUN, one iteration per cycle, with the dividend magnitude shifted MSB-first:
  - r ← {r, next dividend bit}.
  - If r ≥ |B|, then r ← r − |B| and q bit = 1; otherwise q bit = 0.
  - The counter increments; after N iterations, go to FIX.
- FIX:
  - quot ← sign_q ? −q : q, truncated to N bits.
  - rem ← sign_r ? −r : r, truncated to N bits.
  - done ← 1; go to DONE.
- DONE: quot, rem, and done hold until the next load or rst.
- Result semantics match the Verilog signed `/` and `%` operators: truncation toward zero, and the remainder takes the sign of the dividend.
- Overflow: −2^(N−1) / −1 gives quot = −2^(N−1) (wraps) and rem = 0. No flag is raised.
- quot and rem keep their previous values during RUN; they change only in FIX (or the zero-divide path below).
- busy = 1 in RUN and FIX, 0 in IDLE and DONE.

## Timing
- Load sampled at edge k:
  - busy = 1 after edge k.
  - RUN iterations at edges k+1 … k+N.
  - FIX at edge k+N+1: quot, rem, and done=1 visible after edge k+N+1, so latency is N+1 cycles (9 for N=8).
- Load held high for several cycles restarts the division each cycle. The start counts from the last sampled-high edge.
- Load during RUN or FIX aborts the current operation without updating quot/rem, and restarts with the new operands.
- A/B are only sampled on load edges; changes at other times have no effect.
- rst asserted mid-operation clears all state and outputs immediately, independent of clk. After rst deasserts, the block stays in IDLE until a load.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A load with B == 0 skips RUN and goes directly to DONE at the next edge.
  - It sets quot=0, rem=A, div_by_zero=1, done=1, busy=0, giving a 1-cycle latency.
  - div_by_zero clears on the next load or rst.
- DIV_ZERO_DETECT_EN undefined:
  - div_by_zero is tied 0.
  - B == 0 runs the normal N+1-cycle path, giving quotient magnitude 2^N−1 and remainder magnitude |A|.
  - After sign correction: quot = A ≥ 0 ? all-ones : 1, and rem = A.

## Test plan
- N=8, A=100, B=7, load one cycle → done after 9 cycles; quot=14 (0x0E), rem=2 (0x02); busy high for exactly 9 cycles.
- Sign matrix (expected quot, rem):
  - A=−100, B=7 → quot=0xF2 (−14), rem=0xFE (−2).
  - A=100, B=−7 → quot=0xF2, rem=0x02.
  - A=−100, B=−7 → quot=0x0E, rem=0xFE.
- Edge values:
  - A=−128, B=−1 → quot=0x80, rem=0x00.
  - A=−128, B=1 → quot=0x80, rem=0.
  - A=5, B=9 → quot=0, rem=5.
- Divide by zero, A=−20, B=0:
  - With DIV_ZERO_DETECT_EN → after 1 cycle done=1, div_by_zero=1, quot=0, rem=0xEC.
  - Without the macro → after 9 cycles quot=0x01, rem=0xEC, div_by_zero=0.
- Abort: load A=100, B=7, then at cycle 4 load A=50, B=−5 → no intermediate result; done 9 cycles after the second load with quot=0xF6, rem=0.
- Async reset: assert rst mid-RUN between clock edges → all outputs 0 immediately. After release and a new load of A=63, B=8 → quot=7, rem=7.

Source files
------------

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - sequential signed restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes in one cycle with div_by_zero set.
module seq_signed_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_mag;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic          sign_r;

  logic [N-1:0]  a_mag_in;
  logic [N-1:0]  b_mag_in;
  logic [N+1:0]  r_shift;
  logic [N:0]    r_sub;
  logic          r_ge;
  logic          last_iter;

  // Magnitudes are taken as unsigned so |-2^(N-1)| still fits in N bits
  assign a_mag_in  = A[N-1] ? (~A + 1'b1) : A;
  assign b_mag_in  = B[N-1] ? (~B + 1'b1) : B;
  assign r_shift   = {r, a_sh[N-1]};
  assign r_ge      = r_shift >= {2'b00, b_mag};
  assign r_sub     = r_shift[N:0] - {1'b0, b_mag};
  assign last_iter = (cnt == CW'(N - 1));
  assign busy      = (state == RUN) || (state == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (last_iter) next_state = FIX;
      FIX:     next_state = DONE;
      default: next_state = state;
    endcase
    if (load) begin
`ifdef DIV_ZERO_DETECT_EN
      next_state = (B == '0) ? DONE : RUN;
`else
      next_state = RUN;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_mag  <= '0;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot   <= '0;
      rem    <= '0;
      done   <= 1'b0;
    end else if (load) begin
      a_sh   <= a_mag_in;
      b_mag  <= b_mag_in;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      sign_q <= A[N-1] ^ B[N-1];
      sign_r <= A[N-1];
      done   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      if (B == '0) begin
        quot <= '0;
        rem  <= A;
        done <= 1'b1;
      end
`endif
    end else begin
      case (state)
        RUN: begin
          a_sh <= {a_sh[N-2:0], 1'b0};
          r    <= r_ge ? r_sub : r_shift[N:0];
          q    <= {q[N-2:0], r_ge};
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          quot <= sign_q ? (~q + 1'b1) : q;
          rem  <= N'(sign_r ? (~r + 1'b1) : r);
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dz_q <= 1'b0;
    else if (load) dz_q <= (B == '0);
  end

  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider (N=8).
module tb_seq_signed_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc;
  int busy_cnt;

  seq_signed_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .A          (A),
    .B          (B),
    .quot       (quot),
    .rem        (rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts negedges from the one just after the load edge until done rises
  task automatic wait_done();
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_case(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er);
    do_load(a, b);
    wait_done();
    check({tag, "_lat"}, cyc, 9);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    A    = '0;
    B    = '0;
    #1;
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // 100 / 7 with operands disturbed after the load edge
    do_load(8'd100, 8'd7);
    check("basic_busy_start", busy, 1);
    check("basic_done_cleared", done, 0);
    A = 8'h55;
    B = 8'h03;
    wait_done();
    check("basic_lat", cyc, 9);
    check("basic_busy_cycles", busy_cnt, 9);
    check("basic_quot", quot, 8'h0E);
    check("basic_rem", rem, 8'h02);
    check("basic_busy_end", busy, 0);
    @(negedge clk);
    @(negedge clk);
    check("done_hold", done, 1);
    check("quot_hold", quot, 8'h0E);

    run_case("neg_pos", 8'h9C, 8'd7, 8'hF2, 8'hFE);
    run_case("pos_neg", 8'd100, 8'hF9, 8'hF2, 8'h02);
    run_case("neg_neg", 8'h9C, 8'hF9, 8'h0E, 8'hFE);
    run_case("min_m1", 8'h80, 8'hFF, 8'h80, 8'h00);
    run_case("min_p1", 8'h80, 8'h01, 8'h80, 8'h00);
    run_case("small", 8'd5, 8'd9, 8'h00, 8'h05);

    // Divide by zero, A=-20
    do_load(8'hEC, 8'h00);
`ifdef DIV_ZERO_DETECT_EN
    check("dz_done", done, 1);
    check("dz_flag", div_by_zero, 1);
    check("dz_busy", busy, 0);
    check("dz_quot", quot, 8'h00);
    check("dz_rem", rem, 8'hEC);
`else
    wait_done();
    check("dz_lat", cyc, 9);
    check("dz_quot", quot, 8'h01);
    check("dz_rem", rem, 8'hEC);
    check("dz_flag", div_by_zero, 0);
`endif

    // Abort: reload during RUN, previous result must persist until the new one
    run_case("pre_abort", 8'd5, 8'd9, 8'h00, 8'h05);
    do_load(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    do_load(8'd50, 8'hFB);
    check("abort_no_done", done, 0);
    check("abort_quot_kept", quot, 8'h00);
    check("abort_rem_kept", rem, 8'h05);
    wait_done();
    check("abort_lat", cyc, 9);
    check("abort_quot", quot, 8'hF6);
    check("abort_rem", rem, 8'h00);

    // Load held for three edges: latency counts from the last one
    @(negedge clk);
    A = 8'd63;
    B = 8'd9;
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    wait_done();
    check("held_lat", cyc, 9);
    check("held_quot", quot, 8'h07);
    check("held_rem", rem, 8'h00);

    // Asynchronous reset between edges during RUN
    do_load(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_quot", quot, 0);
    check("arst_rem", rem, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_done", done, 0);
    run_case("post_rst", 8'd63, 8'd8, 8'h07, 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
